// File: rtl/apb_ucpd_rx_dec.sv
// UCPD receive decoder: preamble, ordered-set (SOP / Hard Reset / Cable Reset) and 4b5b data/EOP decoding.
// Build option: define UCPD_ORDSET_3OF4_EN to accept an ordered set when 3 of its 4 K-code slots match.
module apb_ucpd_rx_dec (
  input  logic       ic_clk,
  input  logic       ic_rst_n,
  input  logic       ucpden,
  input  logic       rx_en,
  input  logic       rx_bit,
  input  logic       rx_bit_vld,
  output logic       rx_pre_cmplt,
  output logic       rx_sop_cmplt,
  output logic       hrst_vld,
  output logic       crst_vld,
  output logic       rx_ordset_vld,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld,
  output logic       eop_ok,
  output logic       rx_err
);

  localparam logic [4:0] K_SYNC1 = 5'b11000;
  localparam logic [4:0] K_SYNC2 = 5'b10001;
  localparam logic [4:0] K_SYNC3 = 5'b00110;
  localparam logic [4:0] K_RST1  = 5'b00111;
  localparam logic [4:0] K_RST2  = 5'b11001;
  localparam logic [4:0] K_EOP   = 5'b01101;

  // Slot 0 (low bits) is the first K-code received.
  localparam logic [19:0] OS_SOP  = {K_SYNC2, K_SYNC1, K_SYNC1, K_SYNC1};
  localparam logic [19:0] OS_HRST = {K_RST2,  K_RST1,  K_RST1,  K_RST1};
  localparam logic [19:0] OS_CRST = {K_SYNC3, K_RST1,  K_SYNC1, K_RST1};

  localparam logic [8:0] MAX_BYTES = 9'd262;

  typedef enum logic [1:0] {IDLE, PRE, ORDSET, DATA} state_t;

  state_t      state;
  logic [5:0]  pre_cnt;
  logic        pre_last;
  logic [19:0] os_sr;
  logic [3:0]  sym_sr;
  logic [2:0]  bit_cnt;
  logic        sym_odd;
  logic [3:0]  low_nib;
  logic [8:0]  byte_cnt;

  logic [19:0] os_sr_nx;
  logic [4:0]  sym_nx;
  logic [4:0]  dec;
  logic        hr_hit, cr_hit, sop_hit;

  function automatic logic os_match(input logic [19:0] win, input logic [19:0] ks);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++)
      n = n + ((win[5*i +: 5] == ks[5*i +: 5]) ? 3'd1 : 3'd0);
`ifdef UCPD_ORDSET_3OF4_EN
    return (n >= 3'd3);
`else
    return (n == 3'd4);
`endif
  endfunction

  // Returns {valid, nibble}; valid=0 for any non-data symbol.
  function automatic logic [4:0] dec_4b5b(input logic [4:0] s);
    case (s)
      5'b11110: return 5'h10;
      5'b01001: return 5'h11;
      5'b10100: return 5'h12;
      5'b10101: return 5'h13;
      5'b01010: return 5'h14;
      5'b01011: return 5'h15;
      5'b01110: return 5'h16;
      5'b01111: return 5'h17;
      5'b10010: return 5'h18;
      5'b10011: return 5'h19;
      5'b10110: return 5'h1A;
      5'b10111: return 5'h1B;
      5'b11010: return 5'h1C;
      5'b11011: return 5'h1D;
      5'b11100: return 5'h1E;
      5'b11101: return 5'h1F;
      default:  return 5'h00;
    endcase
  endfunction

  assign os_sr_nx = {rx_bit, os_sr[19:1]};
  assign sym_nx   = {rx_bit, sym_sr};
  assign dec      = dec_4b5b(sym_nx);
  assign hr_hit   = os_match(os_sr_nx, OS_HRST);
  assign cr_hit   = os_match(os_sr_nx, OS_CRST);
  assign sop_hit  = os_match(os_sr_nx, OS_SOP);

  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      state         <= IDLE;
      pre_cnt       <= '0;
      pre_last      <= 1'b0;
      os_sr         <= '0;
      sym_sr        <= '0;
      bit_cnt       <= '0;
      sym_odd       <= 1'b0;
      low_nib       <= '0;
      byte_cnt      <= '0;
      rx_pre_cmplt  <= 1'b0;
      rx_sop_cmplt  <= 1'b0;
      hrst_vld      <= 1'b0;
      crst_vld      <= 1'b0;
      rx_ordset_vld <= 1'b0;
      rx_byte       <= 8'h00;
      rx_byte_vld   <= 1'b0;
      eop_ok        <= 1'b0;
      rx_err        <= 1'b0;
    end else begin
      rx_pre_cmplt <= 1'b0;
      rx_sop_cmplt <= 1'b0;
      hrst_vld     <= 1'b0;
      crst_vld     <= 1'b0;
      rx_byte_vld  <= 1'b0;
      eop_ok       <= 1'b0;
      rx_err       <= 1'b0;
      if (!(ucpden && rx_en)) begin
        state    <= IDLE;
        pre_cnt  <= '0;
        os_sr    <= '0;
        sym_sr   <= '0;
        bit_cnt  <= '0;
        sym_odd  <= 1'b0;
        byte_cnt <= '0;
        // A reset ordered set already parked in IDLE keeps its flag until the next frame.
        if (state != IDLE) rx_ordset_vld <= 1'b0;
      end else if (rx_bit_vld) begin
        case (state)
          IDLE: begin
            state         <= PRE;
            pre_cnt       <= 6'd1;
            pre_last      <= rx_bit;
            rx_ordset_vld <= 1'b0;
          end
          PRE: begin
            pre_last <= rx_bit;
            if (rx_bit == pre_last) begin
              pre_cnt <= 6'd1;
            end else if (pre_cnt == 6'd19) begin
              pre_cnt      <= '0;
              rx_pre_cmplt <= 1'b1;
              os_sr        <= '0;
              state        <= ORDSET;
            end else begin
              pre_cnt <= pre_cnt + 6'd1;
            end
          end
          ORDSET: begin
            os_sr <= os_sr_nx;
            if (hr_hit) begin
              hrst_vld      <= 1'b1;
              rx_ordset_vld <= 1'b1;
              state         <= IDLE;
            end else if (cr_hit) begin
              crst_vld      <= 1'b1;
              rx_ordset_vld <= 1'b1;
              state         <= IDLE;
            end else if (sop_hit) begin
              rx_sop_cmplt  <= 1'b1;
              rx_ordset_vld <= 1'b1;
              bit_cnt       <= '0;
              sym_sr        <= '0;
              sym_odd       <= 1'b0;
              byte_cnt      <= '0;
              state         <= DATA;
            end
          end
          DATA: begin
            if (bit_cnt != 3'd4) begin
              sym_sr  <= {rx_bit, sym_sr[3:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end else begin
              bit_cnt <= '0;
              if (sym_nx == K_EOP) begin
                eop_ok        <= 1'b1;
                rx_err        <= sym_odd;
                rx_ordset_vld <= 1'b0;
                state         <= IDLE;
              end else if (!dec[4]) begin
                rx_err        <= 1'b1;
                rx_ordset_vld <= 1'b0;
                state         <= IDLE;
              end else if (!sym_odd) begin
                low_nib <= dec[3:0];
                sym_odd <= 1'b1;
              end else begin
                sym_odd <= 1'b0;
                // byte_cnt stops at the limit, which is where the frame is cut off.
                if (byte_cnt == MAX_BYTES) begin
                  rx_err        <= 1'b1;
                  rx_ordset_vld <= 1'b0;
                  state         <= IDLE;
                end else begin
                  rx_byte     <= {dec[3:0], low_nib};
                  rx_byte_vld <= 1'b1;
                  byte_cnt    <= byte_cnt + 9'd1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_ucpd_rx_dec.sv
// Directed self-checking bench for apb_ucpd_rx_dec; bits are fed one valid strobe every other clock.
module tb_apb_ucpd_rx_dec;

  logic       ic_clk = 1'b0;
  logic       ic_rst_n = 1'b0;
  logic       ucpden = 1'b0;
  logic       rx_en = 1'b0;
  logic       rx_bit = 1'b0;
  logic       rx_bit_vld = 1'b0;
  logic       rx_pre_cmplt, rx_sop_cmplt, hrst_vld, crst_vld, rx_ordset_vld;
  logic [7:0] rx_byte;
  logic       rx_byte_vld, eop_ok, rx_err;

  apb_ucpd_rx_dec dut (
    .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .ucpden(ucpden), .rx_en(rx_en),
    .rx_bit(rx_bit), .rx_bit_vld(rx_bit_vld), .rx_pre_cmplt(rx_pre_cmplt),
    .rx_sop_cmplt(rx_sop_cmplt), .hrst_vld(hrst_vld), .crst_vld(crst_vld),
    .rx_ordset_vld(rx_ordset_vld), .rx_byte(rx_byte), .rx_byte_vld(rx_byte_vld),
    .eop_ok(eop_ok), .rx_err(rx_err)
  );

  always #5 ic_clk = ~ic_clk;

  localparam logic [4:0] S1 = 5'b11000, S2 = 5'b10001, S3 = 5'b00110;
  localparam logic [4:0] R1 = 5'b00111, R2 = 5'b11001, EOP = 5'b01101;

  int checks = 0;
  int errors = 0;
  int bit_idx, pre_at;
  int n_pre, n_sop, n_hr, n_cr, n_eop, n_err, n_both, n_byte;
  logic ord_at_sop;
  logic [7:0] bytes [0:299];

  always @(posedge ic_clk) begin
    #1;
    if (rx_pre_cmplt) begin n_pre++; pre_at = bit_idx; end
    if (rx_sop_cmplt) begin n_sop++; ord_at_sop = rx_ordset_vld; end
    if (hrst_vld) n_hr++;
    if (crst_vld) n_cr++;
    if (eop_ok) n_eop++;
    if (rx_err) n_err++;
    if (eop_ok && rx_err) n_both++;
    if (rx_byte_vld) begin
      if (n_byte < 300) bytes[n_byte] = rx_byte;
      n_byte++;
    end
  end

  function automatic logic [4:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 5'b11110; 4'h1: return 5'b01001; 4'h2: return 5'b10100; 4'h3: return 5'b10101;
      4'h4: return 5'b01010; 4'h5: return 5'b01011; 4'h6: return 5'b01110; 4'h7: return 5'b01111;
      4'h8: return 5'b10010; 4'h9: return 5'b10011; 4'hA: return 5'b10110; 4'hB: return 5'b10111;
      4'hC: return 5'b11010; 4'hD: return 5'b11011; 4'hE: return 5'b11100; default: return 5'b11101;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    bit_idx = 0; pre_at = -1; ord_at_sop = 1'b0;
    n_pre = 0; n_sop = 0; n_hr = 0; n_cr = 0; n_eop = 0; n_err = 0; n_both = 0; n_byte = 0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge ic_clk);
    rx_bit = b; rx_bit_vld = 1'b1; bit_idx++;
    @(negedge ic_clk);
    rx_bit_vld = 1'b0;
  endtask

  task automatic send_sym(input logic [4:0] s);
    for (int i = 0; i < 5; i++) send_bit(s[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_sym(enc(b[3:0]));
    send_sym(enc(b[7:4]));
  endtask

  task automatic send_alt(input int n);
    for (int i = 0; i < n; i++) send_bit(i[0]);
  endtask

  task automatic send_sop();
    send_sym(S1); send_sym(S1); send_sym(S1); send_sym(S2);
  endtask

  task automatic bounce_en();
    @(negedge ic_clk); rx_en = 1'b0;
    @(negedge ic_clk); @(negedge ic_clk); rx_en = 1'b1;
  endtask

  initial begin
    clr_mon();
    repeat (3) @(negedge ic_clk);
    chk("rst_pre", rx_pre_cmplt, 0);
    chk("rst_sop", rx_sop_cmplt, 0);
    chk("rst_hr_cr", {hrst_vld, crst_vld}, 0);
    chk("rst_ordset", rx_ordset_vld, 0);
    chk("rst_byte", rx_byte, 8'h00);
    chk("rst_pulses", {rx_byte_vld, eop_ok, rx_err}, 0);
    ic_rst_n = 1'b1; ucpden = 1'b1; rx_en = 1'b1;
    @(negedge ic_clk);

    // Full frame: 64-bit preamble, SOP, A5, 3C, EOP
    clr_mon();
    send_alt(64); send_sop(); send_byte(8'hA5); send_byte(8'h3C); send_sym(EOP);
    @(negedge ic_clk);
    chk("frm_pre_at", pre_at, 20);
    chk("frm_pre_n", n_pre, 1);
    chk("frm_sop_n", n_sop, 1);
    chk("frm_ordset_at_sop", ord_at_sop, 1);
    chk("frm_byte_n", n_byte, 2);
    chk("frm_byte0", bytes[0], 8'hA5);
    chk("frm_byte1", bytes[1], 8'h3C);
    chk("frm_eop_n", n_eop, 1);
    chk("frm_err_n", n_err, 0);
    chk("frm_ordset_end", rx_ordset_vld, 0);

    // Hard Reset with slot 2 corrupted
    clr_mon();
    send_alt(20); send_sym(R1); send_sym(R1); send_sym(5'b00000); send_sym(R2);
    @(negedge ic_clk);
`ifdef UCPD_ORDSET_3OF4_EN
    chk("hr3_hr_n", n_hr, 1);
    chk("hr3_ordset", rx_ordset_vld, 1);
`else
    chk("hr3_hr_n", n_hr, 0);
    chk("hr3_ordset", rx_ordset_vld, 0);
    send_sop();
    @(negedge ic_clk);
    chk("hr3_still_ordset", n_sop, 1);
`endif
    chk("hr3_cr_n", n_cr, 0);
    bounce_en();

    // Cable Reset keeps rx_ordset_vld until the next frame starts
    clr_mon();
    send_alt(20); send_sym(R1); send_sym(S1); send_sym(R1); send_sym(S3);
    @(negedge ic_clk);
    chk("cr_cr_n", n_cr, 1);
    chk("cr_hr_n", n_hr, 0);
    chk("cr_sop_n", n_sop, 0);
    repeat (2) @(negedge ic_clk);
    chk("cr_ordset_hold", rx_ordset_vld, 1);
    send_bit(1'b0);
    @(negedge ic_clk);
    chk("cr_ordset_clr", rx_ordset_vld, 0);
    bounce_en();

    // Odd-nibble EOP
    clr_mon();
    send_alt(20); send_sop(); send_sym(enc(4'h7)); send_sym(EOP);
    @(negedge ic_clk);
    chk("half_both", n_both, 1);
    chk("half_eop_n", n_eop, 1);
    chk("half_byte_n", n_byte, 0);

    // Invalid symbol, then the next bit must start a fresh preamble
    clr_mon();
    send_alt(20); send_sop(); send_sym(5'b00000);
    @(negedge ic_clk);
    chk("bad_err_n", n_err, 1);
    chk("bad_eop_n", n_eop, 0);
    chk("bad_byte_n", n_byte, 0);
    clr_mon();
    send_alt(20);
    @(negedge ic_clk);
    chk("bad_restart_pre", pre_at, 20);
    bounce_en();

    // Byte limit
    clr_mon();
    send_alt(20); send_sop();
    for (int i = 0; i < 263; i++) send_byte(i[7:0]);
    @(negedge ic_clk);
    chk("ovf_byte_n", n_byte, 262);
    chk("ovf_err_n", n_err, 1);
    chk("ovf_byte100", bytes[100], 8'd100);
    chk("ovf_last", bytes[261], 8'h05);
    chk("ovf_ordset", rx_ordset_vld, 0);

    // rx_en dropped mid-DATA
    clr_mon();
    send_alt(20); send_sop(); send_byte(8'h5A); send_sym(enc(4'h1));
    @(negedge ic_clk); rx_en = 1'b0;
    @(negedge ic_clk);
    chk("dis_ordset_next", rx_ordset_vld, 0);
    send_sym(enc(4'h2)); send_sym(EOP);
    @(negedge ic_clk);
    chk("dis_byte_n", n_byte, 1);
    chk("dis_byte0", bytes[0], 8'h5A);
    chk("dis_eop_err", n_eop + n_err, 0);
    rx_en = 1'b1;
    clr_mon();
    send_alt(20);
    @(negedge ic_clk);
    chk("dis_restart_pre", pre_at, 20);
    bounce_en();

    // Reset mid-frame
    clr_mon();
    send_alt(20); send_sop(); send_bit(1'b1); send_bit(1'b0);
    @(negedge ic_clk);
    chk("rmf_ordset_before", rx_ordset_vld, 1);
    ic_rst_n = 1'b0;
    @(negedge ic_clk);
    chk("rmf_ordset", rx_ordset_vld, 0);
    ic_rst_n = 1'b1;
    repeat (3) @(negedge ic_clk);
    chk("rmf_eop_err", n_eop + n_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
